// File: rtl/nios32_button_debounce.sv
// Push-button conditioner: per-bit synchroniser followed by a per-bit stability-counter debouncer.
// A change on a bit is accepted only after the synchronised value has differed from the
// debounced value for DEBOUNCE_CYCLES consecutive clocks.
// Optional feature macro: BUTTON_DEBOUNCE_PRESS_PULSE_EN adds a one-cycle press_pulse
// output, asserted on each 1->0 transition of debounced.
module nios32_button_debounce #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      SYNC_STAGES     = 2,       // legal range 2..3
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,  // >= 2
  parameter int unsigned      CNT_W           = 19,      // must hold DEBOUNCE_CYCLES-1
  parameter logic [WIDTH-1:0] RESET_VAL       = '1       // keys released
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
  ,
  output logic [WIDTH-1:0] press_pulse
`endif
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_q;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0][CNT_W-1:0]       r_cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0]       w_cnt_d;
  logic [WIDTH-1:0]                  r_deb_q;
  logic [WIDTH-1:0]                  w_deb_d;

  // Synchroniser chain: plain flop-to-flop, no logic between stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync_q[0] <= raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync_q[k] <= r_sync_q[k-1];
      end
    end
  end

  assign w_sync = r_sync_q[SYNC_STAGES-1];

  // Per-bit stability window: any sample equal to the debounced value restarts it;
  // the last cycle of a full window accepts the new level and clears the counter.
  always_comb begin
    w_cnt_d = r_cnt_q;
    w_deb_d = r_deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_sync[i] == r_deb_q[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt_q[i] == CntMax) begin
        w_deb_d[i] = w_sync[i];
        w_cnt_d[i] = '0;
      end else begin
        w_cnt_d[i] = r_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter and debounced-level state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_q <= '0;
      r_deb_q <= RESET_VAL;
    end else begin
      r_cnt_q <= w_cnt_d;
      r_deb_q <= w_deb_d;
    end
  end

  assign debounced = r_deb_q;

`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
  logic [WIDTH-1:0] r_pulse_q;

  // Pulse rises on the same edge debounced falls (press); releases never pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse_q <= '0;
    end else begin
      r_pulse_q <= r_deb_q & ~w_deb_d;
    end
  end

  assign press_pulse = r_pulse_q;
`endif

endmodule

// File: tb/tb_nios32_button_debounce.sv
// Self-checking bench for nios32_button_debounce (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Reference model: debounced[i] flips at edge n when the synchronised sample of bit i
// differed from the current debounced value on each of the last DEBOUNCE_CYCLES edges
// since reset release; the synchronised sample at edge n is the raw level SYNC_STAGES
// edges earlier.
module tb_nios32_button_debounce;

  localparam int W    = 4;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int MAXN = 8192;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] debounced;
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
  logic [W-1:0] press_pulse;
`endif

  always #5 clk = ~clk;

  nios32_button_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (19),
    .RESET_VAL      (4'hF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_in     (raw_in),
    .debounced  (debounced)
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
    ,
    .press_pulse(press_pulse)
`endif
  );

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] hist [MAXN];  // hist[m]: raw level present before edge m
  int           n;            // edges since reset release
  logic [W-1:0] mdl_deb;
  logic [W-1:0] mdl_pulse;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, edge %0d)", tag, got, exp, $time, n);
    end
  endtask

  // Synchronised sample of bit i seen at edge k (reset value until raw data arrives).
  function automatic logic s_at(int k, int i);
    return (k - S >= 1) ? hist[k-S][i] : 1'b1;
  endfunction

  task automatic model_edge();
    logic flip;
    mdl_pulse = '0;
    for (int i = 0; i < W; i++) begin
      flip = 1'b0;
      if (n >= D) begin
        flip = 1'b1;
        for (int k = n - D + 1; k <= n; k++) begin
          if (s_at(k, i) == mdl_deb[i]) flip = 1'b0;
        end
      end
      if (flip) begin
        mdl_pulse[i] = mdl_deb[i];
        mdl_deb[i]   = ~mdl_deb[i];
      end
    end
  endtask

  // One clock: drive raw, advance model on the edge, compare on the falling edge.
  task automatic step(input logic [W-1:0] v);
    raw_in = v;
    if (n + 1 >= MAXN) begin
      $display("FAIL history_overflow: got %0d expected <%0d", n + 1, MAXN);
      $fatal(1, "history overflow");
    end
    hist[n+1] = v;
    @(posedge clk);
    n++;
    model_edge();
    @(negedge clk);
    check_eq("deb_model", debounced, mdl_deb);
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
    check_eq("pulse_model", press_pulse, mdl_pulse);
`endif
  endtask

  // Asynchronous reset pulse starting mid-cycle; released on a falling edge.
  task automatic do_reset(input logic [W-1:0] v);
    raw_in  = v;
    reset_n = 1'b0;
    #1;
    check_eq("rst_deb_async", debounced, 4'hF);
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
    check_eq("rst_pulse", press_pulse, 4'h0);
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_deb_hold", debounced, 4'hF);
    reset_n   = 1'b1;
    n         = 0;
    mdl_deb   = 4'hF;
    mdl_pulse = 4'h0;
  endtask

  initial begin
    logic [W-1:0] v;
    int           lim;
    reset_n = 1'b1;
    raw_in  = 4'hF;
    n       = 0;
    mdl_deb = 4'hF;
    @(negedge clk);

    // 1: raw low through reset; falls exactly 6 cycles after release.
    do_reset(4'h0);
    for (int c = 1; c <= 6; c++) begin
      step(4'h0);
      if (c < 6) check_eq("t1_hold", debounced, 4'hF);
    end
    check_eq("t1_fall", debounced, 4'h0);

    // 2: single press on bit 0 from steady released state.
    do_reset(4'hF);
    repeat (8) step(4'hF);
    for (int c = 1; c <= 6; c++) begin
      step(4'hE);
      if (c < 6) check_eq("t2_hold", debounced, 4'hF);
    end
    check_eq("t2_fall", debounced, 4'hE);

    // 3: bit 1 bounces every 2 cycles, then settles low.
    do_reset(4'hF);
    repeat (8) step(4'hF);
    for (int c = 0; c < 20; c++) begin
      v    = 4'hF;
      v[1] = ((c / 2) % 2) != 0;
      step(v);
      check_eq("t3_bounce", debounced[1], 1'b1);
    end
    for (int c = 1; c <= 6; c++) begin
      step(4'hD);
      if (c < 6) check_eq("t3_hold", debounced[1], 1'b1);
    end
    check_eq("t3_fall", debounced[1], 1'b0);

    // 4: bits 2 and 3 drop one cycle apart.
    do_reset(4'hF);
    repeat (8) step(4'hF);
    step(4'hB);
    for (int c = 2; c <= 7; c++) begin
      step(4'h3);
      if (c == 6) check_eq("t4_bit2", debounced, 4'hB);
    end
    check_eq("t4_bit3", debounced, 4'h3);

    // 5: reset mid-count discards the window.
    do_reset(4'hF);
    repeat (8) step(4'hF);
    repeat (4) step(4'hE);
    check_eq("t5_precount", debounced, 4'hF);
    do_reset(4'hE);
    for (int c = 1; c <= 6; c++) begin
      step(4'hE);
      if (c < 6) check_eq("t5_hold", debounced[0], 1'b1);
    end
    check_eq("t5_fall", debounced[0], 1'b0);

`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
    // 6: press then release of bit 3.
    do_reset(4'hF);
    repeat (8) step(4'hF);
    for (int c = 1; c <= 6; c++) begin
      step(4'h7);
      if (c < 6) check_eq("t6_nopulse", press_pulse, 4'h0);
    end
    check_eq("t6_pulse", press_pulse, 4'h8);
    step(4'h7);
    check_eq("t6_pulse_end", press_pulse, 4'h0);
    for (int c = 1; c <= 6; c++) begin
      step(4'hF);
      check_eq("t6_release", press_pulse, 4'h0);
    end
    check_eq("t6_released", debounced, 4'hF);
`endif

    // Random bounce with varying toggle rates and occasional mid-run resets.
    for (int seg = 0; seg < 40; seg++) begin
      if (seg % 10 == 0) do_reset(4'($urandom));
      case ($urandom_range(0, 3))
        0:       lim = 1;
        1:       lim = 3;
        2:       lim = 7;
        default: lim = 15;
      endcase
      v = raw_in;
      for (int c = 0; c < 80; c++) begin
        for (int i = 0; i < W; i++) begin
          if ($urandom_range(0, lim) == 0) v[i] = ~v[i];
        end
        step(v);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
